alu_exec_stage: RTL and testbench

Pipelined execute-stage wrapper that sits directly upstream of the combinational ALU and consumes its result. It accepts operand/opcode requests over a valid/ready handshake, registers them onto the ALU inputs, captures the ALU result and carry into a 2-entry result FIFO, and presents results downstream over a second valid/ready handshake. It sustains one operation per cycle when the downstream consumer is always ready.

---
 rtl/alu_exec_stage.sv | 129 ++++++++++++
 tb/tb_alu_exec_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage around an external combinational ALU: registers requests onto the
// ALU inputs and buffers results in a 2-entry FIFO. Optional macro: ALU_EXEC_STICKY_COUT_EN.
module alu_exec_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_A,
  input  logic [31:0] IN_B,
  input  logic [3:0]  IN_OP,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [3:0]  ALU_OP,
  input  logic [31:0] ALU_C,
  input  logic        ALU_COUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_C,
  output logic        OUT_COUT,
  output logic [15:0] RESULT_CNT,
  output logic        STICKY_COUT,
  input  logic        CLR_STICKY
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic        op_valid;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [3:0]  op_reg;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [32:0] fifo_mem [2];
  logic [15:0] result_cnt_reg;
  logic        accept;
  logic        push;
  logic        pop;
  logic        masked_cout;

  assign pop       = (count != 2'd0) && OUT_READY;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push      = op_valid && ((count < FULL) || pop);
  assign IN_READY  = !op_valid || push;
  assign accept    = IN_VALID && IN_READY;

  // Carry is only meaningful for add (0000) and sub (0001).
  assign masked_cout = ALU_COUT && (op_reg[3:1] == 3'b000);

  assign ALU_A      = a_reg;
  assign ALU_B      = b_reg;
  assign ALU_OP     = op_reg;
  assign OUT_VALID  = (count != 2'd0);
  assign OUT_C      = fifo_mem[rd_ptr][31:0];
  assign OUT_COUT   = fifo_mem[rd_ptr][32];
  assign RESULT_CNT = result_cnt_reg;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_valid <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
    end else begin
      if (accept) begin
        op_valid <= 1'b1;
        a_reg    <= IN_A;
        b_reg    <= IN_B;
        op_reg   <= IN_OP;
      end else if (push) begin
        op_valid <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr == 1'(gi))) begin
          fifo_mem[gi] <= {masked_cout, ALU_C};
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count          <= 2'd0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      result_cnt_reg <= 16'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr         <= ~rd_ptr;
        result_cnt_reg <= result_cnt_reg + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_EXEC_STICKY_COUT_EN
  logic sticky_reg;
  // Set wins over a coincident clear so no carry event is lost.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sticky_reg <= 1'b0;
    end else if (push && masked_cout) begin
      sticky_reg <= 1'b1;
    end else if (CLR_STICKY) begin
      sticky_reg <= 1'b0;
    end
  end
  assign STICKY_COUT = sticky_reg;
`else
  logic unused_clr;
  assign unused_clr  = CLR_STICKY;
  assign STICKY_COUT = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: models the external ALU and keeps a
// scoreboard of expected results filled on accept and drained on pop.
module tb_alu_exec_stage;

`ifdef ALU_EXEC_STICKY_COUT_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_A = '0;
  logic [31:0] IN_B = '0;
  logic [3:0]  IN_OP = '0;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [3:0]  ALU_OP;
  logic [31:0] ALU_C;
  logic        ALU_COUT;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_C;
  logic        OUT_COUT;
  logic [15:0] RESULT_CNT;
  logic        STICKY_COUT;
  logic        CLR_STICKY = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int pop_count = 0;
  logic [32:0] sb [$];

  always #5 CLK = ~CLK;

  alu_exec_stage #(.FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_OP(IN_OP),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP),
    .ALU_C(ALU_C), .ALU_COUT(ALU_COUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_C(OUT_C), .OUT_COUT(OUT_COUT),
    .RESULT_CNT(RESULT_CNT), .STICKY_COUT(STICKY_COUT), .CLR_STICKY(CLR_STICKY)
  );

  // Reference ALU: add/sub produce carry/borrow; the logic ops also report the
  // add carry so the stage's masking is actually exercised.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      4'b0000: alu_model = sum;
      4'b0001: alu_model = {1'b0, a} - {1'b0, b};
      4'b0010: alu_model = {sum[32], a & b};
      4'b0011: alu_model = {sum[32], a | b};
      default: alu_model = {sum[32], a ^ b};
    endcase
  endfunction

  always_comb begin
    {ALU_COUT, ALU_C} = alu_model(ALU_A, ALU_B, ALU_OP);
  end

  // Monitor: inputs are stable between the negedge and the next posedge.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (OUT_VALID && OUT_READY) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got C=%h COUT=%b, required no output", OUT_C, OUT_COUT);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          if ({OUT_COUT, OUT_C} !== e) begin
            n_fail++;
            $display("FAIL pop_data: got COUT=%b C=%h, required COUT=%b C=%h",
                     OUT_COUT, OUT_C, e[32], e[31:0]);
          end
        end
        n_checks++;
        if (RESULT_CNT !== 16'(pop_count)) begin
          n_fail++;
          $display("FAIL result_cnt_at_pop: got %0d, required %0d", RESULT_CNT, pop_count);
        end
        pop_count++;
      end
      if (IN_VALID && IN_READY) begin
        logic [32:0] r;
        r = alu_model(IN_A, IN_B, IN_OP);
        if (IN_OP[3:1] != 3'b000) r[32] = 1'b0;
        sb.push_back(r);
        $display("accept A=%h B=%h OP=%b exp C=%h COUT=%b", IN_A, IN_B, IN_OP, r[31:0], r[32]);
      end
    end
  end

  // Called at posedge+1; holds the request until accepted, returns at posedge+1.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      output int stalls);
    stalls = 0;
    IN_VALID = 1'b1; IN_A = a; IN_B = b; IN_OP = op;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        return;
      end
      stalls++;
      @(posedge CLK); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL send_timeout: got IN_READY=0 for 50 cycles, required acceptance");
    IN_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !OUT_VALID) begin
        @(posedge CLK); #1;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    #12;
    n_checks++;
    if ({IN_READY, OUT_VALID, ALU_A, ALU_B, ALU_OP, OUT_C, OUT_COUT, RESULT_CNT, STICKY_COUT}
        !== {1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b ov=%b A=%h B=%h OP=%h C=%h co=%b cnt=%0d st=%b, required rdy=1 others 0",
               IN_READY, OUT_VALID, ALU_A, ALU_B, ALU_OP, OUT_C, OUT_COUT, RESULT_CNT, STICKY_COUT);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic_latency();
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; IN_A = 32'hFFFF_FFFF; IN_B = 32'd1; IN_OP = 4'b0000;
    @(negedge CLK);
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b, required 1", IN_READY);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0 || ALU_A !== 32'hFFFF_FFFF || ALU_B !== 32'd1) begin
      n_fail++;
      $display("FAIL basic_stage1: got ov=%b A=%h B=%h, required ov=0 A=ffffffff B=00000001",
               OUT_VALID, ALU_A, ALU_B);
    end
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT_C !== 32'd0 || OUT_COUT !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_result: got ov=%b C=%h co=%b, required ov=1 C=00000000 co=1",
               OUT_VALID, OUT_C, OUT_COUT);
    end
    @(negedge CLK);
    n_checks++;
    if (RESULT_CNT !== 16'd1 || OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_count: got cnt=%0d ov=%b, required cnt=1 ov=0", RESULT_CNT, OUT_VALID);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    int stalls;
    int total;
    total = 0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'(i), 32'd2, 4'b0000, stalls);
      total += stalls;
    end
    wait_drain();
    n_checks++;
    if (total !== 0) begin
      n_fail++; $display("FAIL b2b_stalls: got %0d stall cycles, required 0", total);
    end
    n_checks++;
    if (RESULT_CNT !== 16'd9) begin
      n_fail++; $display("FAIL b2b_count: got %0d, required 9", RESULT_CNT);
    end
  endtask

  task automatic test_backpressure();
    int stalls;
    int total;
    total = 0;
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'h100 + 32'(i), 32'h10, 4'b0011, stalls);
      total += stalls;
    end
    n_checks++;
    if (total !== 0) begin
      n_fail++; $display("FAIL bp_first3: got %0d stalls, required 0", total);
    end
    IN_VALID = 1'b1; IN_A = 32'h5555_0000; IN_B = 32'h0000_AAAA; IN_OP = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall: got rdy=%b ov=%b, required rdy=0 ov=1", IN_READY, OUT_VALID);
      end
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got rdy=%b, required 1", IN_READY);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    wait_drain();
    n_checks++;
    if (RESULT_CNT !== 16'd13) begin
      n_fail++; $display("FAIL bp_count: got %0d, required 13", RESULT_CNT);
    end
  endtask

  task automatic test_carry_mask();
    int stalls;
    OUT_READY = 1'b1;
    send(32'hFFFF_FFFF, 32'd1, 4'b0000, stalls);
    send(32'hFFFF_FFFF, 32'd1, 4'b0010, stalls);
    send(32'd0, 32'd1, 4'b0001, stalls);
    send(32'hF000_0000, 32'h1000_0000, 4'b0111, stalls);
    wait_drain();
    n_checks++;
    if (RESULT_CNT !== 16'd17) begin
      n_fail++; $display("FAIL mask_count: got %0d, required 17", RESULT_CNT);
    end
  endtask

  task automatic test_sticky();
    int stalls;
    OUT_READY = 1'b1;
    CLR_STICKY = 1'b1;
    @(posedge CLK); #1;
    CLR_STICKY = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (STICKY_COUT !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clear: got %b, required 0", STICKY_COUT);
    end
    @(posedge CLK); #1;
    send(32'd1, 32'd1, 4'b0000, stalls);
    wait_drain();
    n_checks++;
    if (STICKY_COUT !== 1'b0) begin
      n_fail++; $display("FAIL sticky_nocarry: got %b, required 0", STICKY_COUT);
    end
    send(32'h8000_0000, 32'h8000_0000, 4'b0000, stalls);
    @(negedge CLK);
    n_checks++;
    if (STICKY_COUT !== 1'b0) begin
      n_fail++; $display("FAIL sticky_before_push: got %b, required 0", STICKY_COUT);
    end
    @(negedge CLK);
    n_checks++;
    if (STICKY_COUT !== STICKY_EN) begin
      n_fail++; $display("FAIL sticky_set: got %b, required %b", STICKY_COUT, STICKY_EN);
    end
    @(posedge CLK); #1;
    wait_drain();
    CLR_STICKY = 1'b1;
    @(posedge CLK); #1;
    CLR_STICKY = 1'b0;
    send(32'h8000_0000, 32'h8000_0000, 4'b0000, stalls);
    CLR_STICKY = 1'b1;
    @(posedge CLK); #1;
    CLR_STICKY = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (STICKY_COUT !== STICKY_EN) begin
      n_fail++; $display("FAIL sticky_set_wins: got %b, required %b", STICKY_COUT, STICKY_EN);
    end
    @(posedge CLK); #1;
    wait_drain();
  endtask

  task automatic test_async_reset();
    int stalls;
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h77 + 32'(i), 32'd3, 4'b0000, stalls);
    #3;
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({IN_READY, OUT_VALID, ALU_A, ALU_B, ALU_OP, OUT_C, OUT_COUT, RESULT_CNT, STICKY_COUT}
        !== {1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b ov=%b A=%h B=%h OP=%h C=%h co=%b cnt=%0d st=%b, required rdy=1 others 0",
               IN_READY, OUT_VALID, ALU_A, ALU_B, ALU_OP, OUT_C, OUT_COUT, RESULT_CNT, STICKY_COUT);
    end
    sb.delete();
    pop_count = 0;
    @(negedge CLK);
    #2;
    RSTn = 1'b1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_checks++;
      if (OUT_VALID !== 1'b0) begin
        n_fail++; $display("FAIL async_ghost: got ov=%b C=%h, required ov=0", OUT_VALID, OUT_C);
      end
    end
    @(posedge CLK); #1;
    send(32'd40, 32'd2, 4'b0000, stalls);
    wait_drain();
    n_checks++;
    if (RESULT_CNT !== 16'd1) begin
      n_fail++; $display("FAIL async_resume: got %0d, required 1", RESULT_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_back_to_back();
    test_backpressure();
    test_carry_mask();
    test_sticky();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
